// File: rtl/aes_round_ctrl.sv
// AES round controller: key-expansion kick-off, round sequencing and block handshakes.
// Optional block counter output blk_cnt is built when AES_ROUND_CTRL_PERF_CNT_EN is defined.
module aes_round_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_load,
    input  logic [1:0]  key_len,
    output logic        kx_start,
    output logic [3:0]  kx_nk,
    output logic [3:0]  rk_addr,
    output logic        key_valid,
    input  logic        din_valid,
    output logic        din_ready,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        rnd_load,
    output logic        rnd_en,
    output logic        rnd_final
`ifdef AES_ROUND_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] blk_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEXP  = 3'd1,
        READY = 3'd2,
        RUN   = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  kx_nk_r;
    logic [4:0]  wait_cnt_r;
    logic [3:0]  rnd_cnt_r;
    logic [3:0]  nr_s;
    logic        load_key_s;

    // Reserved key length 11 falls back to the AES-128 code.
    function automatic logic [3:0] nk_of(input logic [1:0] len);
        logic [3:0] nk;
        case (len)
            2'b01:   nk = 4'd5;
            2'b10:   nk = 4'd7;
            default: nk = 4'd3;
        endcase
        return nk;
    endfunction

    function automatic logic [3:0] nr_of(input logic [3:0] nk);
        logic [3:0] nr;
        case (nk)
            4'd5:    nr = 4'd12;
            4'd7:    nr = 4'd14;
            default: nr = 4'd10;
        endcase
        return nr;
    endfunction

    assign nr_s = nr_of(kx_nk_r);

    // Next-state logic; key_load takes priority over a pending input block in READY.
    always_comb begin
        state_s    = state_r;
        load_key_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (key_load) begin
                    state_s    = KEXP;
                    load_key_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            KEXP: begin
                if (wait_cnt_r == ({1'b0, nr_s} + 5'd3)) begin
                    state_s = READY;
                end else begin
                    state_s = KEXP;
                end
            end
            READY: begin
                if (key_load) begin
                    state_s    = KEXP;
                    load_key_s = 1'b1;
                end else if (din_valid) begin
                    state_s = RUN;
                end else begin
                    state_s = READY;
                end
            end
            RUN: begin
                if (rnd_cnt_r == nr_s) begin
                    state_s = OUT;
                end else begin
                    state_s = RUN;
                end
            end
            OUT: begin
                if (dout_ready) begin
                    state_s = READY;
                end else begin
                    state_s = OUT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Key-size code latched on an accepted key_load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kx_nk_r <= 4'd3;
        end else if (load_key_s) begin
            kx_nk_r <= nk_of(key_len);
        end else begin
            kx_nk_r <= kx_nk_r;
        end
    end

    // Fixed-latency wait for the key expansion block; it has no done handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= 5'd0;
        end else if (state_r == KEXP) begin
            wait_cnt_r <= wait_cnt_r + 5'd1;
        end else begin
            wait_cnt_r <= 5'd0;
        end
    end

    // Round index: 0 is the initial AddRoundKey, 1..Nr the cipher rounds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_cnt_r <= 4'd0;
        end else if ((state_r == RUN) && (rnd_cnt_r != nr_s)) begin
            rnd_cnt_r <= rnd_cnt_r + 4'd1;
        end else begin
            rnd_cnt_r <= 4'd0;
        end
    end

    assign kx_nk      = kx_nk_r;
    assign kx_start   = (state_r == KEXP) && (wait_cnt_r == 5'd0);
    assign key_valid  = (state_r == READY) || (state_r == RUN) || (state_r == OUT);
    assign din_ready  = (state_r == READY) && !key_load;
    assign dout_valid = (state_r == OUT);
    assign rnd_load   = (state_r == RUN) && (rnd_cnt_r == 4'd0);
    assign rnd_en     = (state_r == RUN) && (rnd_cnt_r != 4'd0);
    assign rnd_final  = (state_r == RUN) && (rnd_cnt_r == nr_s);
    assign rk_addr    = (state_r == RUN) ? rnd_cnt_r : 4'd0;

`ifdef AES_ROUND_CTRL_PERF_CNT_EN
    logic [31:0] blk_cnt_r;

    // Saturating count of delivered blocks, cleared with each new key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_r <= 32'd0;
        end else if (load_key_s) begin
            blk_cnt_r <= 32'd0;
        end else if ((state_r == OUT) && dout_ready && (blk_cnt_r != 32'hFFFF_FFFF)) begin
            blk_cnt_r <= blk_cnt_r + 32'd1;
        end else begin
            blk_cnt_r <= blk_cnt_r;
        end
    end

    assign blk_cnt = blk_cnt_r;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: directed scenarios plus random traffic against a timestamp-based model.
module tb_aes_round_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_load;
    logic [1:0]  key_len;
    logic        kx_start;
    logic [3:0]  kx_nk;
    logic [3:0]  rk_addr;
    logic        key_valid;
    logic        din_valid;
    logic        din_ready;
    logic        dout_valid;
    logic        dout_ready;
    logic        rnd_load;
    logic        rnd_en;
    logic        rnd_final;
`ifdef AES_ROUND_CTRL_PERF_CNT_EN
    logic [31:0] blk_cnt;
`endif

    always #5 clk = ~clk;

    aes_round_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_load   (key_load),
        .key_len    (key_len),
        .kx_start   (kx_start),
        .kx_nk      (kx_nk),
        .rk_addr    (rk_addr),
        .key_valid  (key_valid),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .rnd_load   (rnd_load),
        .rnd_en     (rnd_en),
        .rnd_final  (rnd_final)
`ifdef AES_ROUND_CTRL_PERF_CNT_EN
        ,
        .blk_cnt    (blk_cnt)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    // Model: key loaded flag, first key-expansion cycle, Nr, accepted-block cycle (-1 = none).
    bit          m_key;
    int          m_k;
    int          m_nr;
    int          m_blk;
    logic [3:0]  m_nk;
    logic [31:0] m_cnt;
    bit          p_kexp, p_run, p_out, p_rdy;
    int          p_r;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_key = 1'b0;
        m_k   = -100;
        m_nr  = 10;
        m_blk = -1;
        m_nk  = 4'd3;
        m_cnt = 32'd0;
    endtask

    task automatic derive();
        p_kexp = m_key && (cyc < m_k + m_nr + 4);
        p_r    = cyc - m_blk - 1;
        p_run  = (m_blk >= 0) && (p_r >= 0) && (p_r <= m_nr);
        p_out  = (m_blk >= 0) && (p_r > m_nr);
        p_rdy  = m_key && !p_kexp && (m_blk < 0);
    endtask

    task automatic check_outputs();
        check_eq("kx_start",   {31'd0, kx_start},   {31'd0, m_key && (cyc == m_k)});
        check_eq("kx_nk",      {28'd0, kx_nk},      {28'd0, m_nk});
        check_eq("key_valid",  {31'd0, key_valid},  {31'd0, m_key && !p_kexp});
        check_eq("din_ready",  {31'd0, din_ready},  {31'd0, p_rdy && !key_load});
        check_eq("dout_valid", {31'd0, dout_valid}, {31'd0, p_out});
        check_eq("rnd_load",   {31'd0, rnd_load},   {31'd0, p_run && (p_r == 0)});
        check_eq("rnd_en",     {31'd0, rnd_en},     {31'd0, p_run && (p_r > 0)});
        check_eq("rnd_final",  {31'd0, rnd_final},  {31'd0, p_run && (p_r == m_nr)});
        check_eq("rk_addr",    {28'd0, rk_addr},    p_run ? 32'(p_r) : 32'd0);
`ifdef AES_ROUND_CTRL_PERF_CNT_EN
        check_eq("blk_cnt",    blk_cnt,             m_cnt);
`endif
    endtask

    task automatic model_edge();
        if ((!m_key || p_rdy) && key_load) begin
            m_key = 1'b1;
            m_k   = cyc + 1;
            m_nk  = (key_len == 2'b01) ? 4'd5 : ((key_len == 2'b10) ? 4'd7 : 4'd3);
            m_nr  = 4 + 2 * (32'(m_nk) + 1) / 2 + 2;
            m_nr  = (m_nk == 4'd5) ? 12 : ((m_nk == 4'd7) ? 14 : 10);
            m_cnt = 32'd0;
        end else if (p_rdy && din_valid) begin
            m_blk = cyc;
        end
        if (p_out && dout_ready) begin
            m_blk = -1;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model at the rising edge.
    task automatic step(input bit kl, input logic [1:0] kln, input bit dv, input bit dr);
        key_load   = kl;
        key_len    = kln;
        din_valid  = dv;
        dout_ready = dr;
        @(negedge clk);
        derive();
        check_outputs();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic idle_steps(input int n, input bit dr);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, dr);
    endtask

    // Asynchronous reset pulse taken mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_kx_start",   {31'd0, kx_start},   32'd0);
        check_eq("rst_key_valid",  {31'd0, key_valid},  32'd0);
        check_eq("rst_din_ready",  {31'd0, din_ready},  32'd0);
        check_eq("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
        check_eq("rst_strobes",    {29'd0, rnd_load, rnd_en, rnd_final}, 32'd0);
        check_eq("rst_rk_addr",    {28'd0, rk_addr},    32'd0);
        check_eq("rst_kx_nk",      {28'd0, kx_nk},      32'd3);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        key_load   = 1'b0;
        key_len    = 2'b00;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        rst_n      = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // AES-128 key expansion from cycle 0.
        step(1'b1, 2'b00, 1'b0, 1'b0);
        idle_steps(16, 1'b0);

        // AES-256 key, one block with output held back for extra cycles.
        step(1'b1, 2'b10, 1'b0, 1'b0);
        idle_steps(20, 1'b0);
        step(1'b0, 2'b00, 1'b1, 1'b0);
        idle_steps(21, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b1);
        idle_steps(2, 1'b0);

        // key_load during RUN is ignored.
        step(1'b0, 2'b00, 1'b1, 1'b0);
        idle_steps(3, 1'b0);
        step(1'b1, 2'b01, 1'b0, 1'b0);
        idle_steps(14, 1'b1);

        // key_load and din_valid together in READY.
        step(1'b1, 2'b00, 1'b1, 1'b0);
        idle_steps(16, 1'b0);

        // Three blocks, then a new key clears the block count.
        for (int b = 0; b < 3; b++) begin
            step(1'b0, 2'b00, 1'b1, 1'b0);
            idle_steps(12, 1'b1);
        end
        step(1'b1, 2'b11, 1'b0, 1'b0);
        idle_steps(16, 1'b0);

        // Reset during round 5, then din_valid alone must not be accepted.
        step(1'b0, 2'b00, 1'b1, 1'b0);
        idle_steps(5, 1'b0);
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 2'b00, 1'b1, 1'b1);
        step(1'b1, 2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 2'b00, 1'b1, 1'b1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 24) == 0, 2'($urandom_range(0, 3)),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have ports clk (in, 1, clock) and rst_n (in, 1, reset); one clock; reset is asynchronous and active-low.
REQ-002 SHALL have key_load (in, 1): pulse requesting a new key expansion.
REQ-003 SHALL have key_len (in, 2): 00=AES-128, 01=AES-192, 10=AES-256, 11=reserved; sampled on key_load.
REQ-004 SHALL have kx_start (out, 1): start strobe to the key expansion block's k_ready input.
REQ-005 SHALL have kx_nk (out, 4): key-size code to the key expansion block: 3/5/7 for 128/192/256.
REQ-006 SHALL have rk_addr (out, 4): round-key address to the key expansion block's Addr input.
REQ-007 SHALL have key_valid (out, 1): expanded key usable.
REQ-008 SHALL have din_valid (in, 1) and din_ready (out, 1): input block handshake.
REQ-009 SHALL have dout_valid (out, 1) and dout_ready (in, 1): output block handshake.
REQ-010 SHALL have rnd_load (out, 1), rnd_en (out, 1), rnd_final (out, 1): round datapath strobes for initial AddRoundKey, normal round, and last round (no MixColumns).

Function
REQ-011 SHALL implement states IDLE, KEXP, READY, RUN, OUT.
REQ-012 SHALL set Nr=10/12/14 for key_len 00/01/10; key_len 11 SHALL behave as 00.
REQ-013 IDLE or READY with key_load=1 SHALL latch key_len and go to KEXP; key_valid drops the next cycle.
REQ-014 kx_start SHALL be high for exactly the first KEXP cycle K; kx_nk SHALL hold the latched code from K onward.
REQ-015 KEXP SHALL go to READY so that key_valid=1 from cycle K+Nr+4 (wait counter, no handshake from key expansion).
REQ-016 din_ready SHALL be 1 only in READY (combinational from state) and key_load=0 in that cycle; key_load has priority over din_valid.
REQ-017 A din_valid&din_ready handshake at cycle T SHALL give: T+1 RUN, rnd_load=1, rk_addr=0; cycles T+1+r (r=1..Nr) rnd_en=1, rk_addr=r, rnd_final=(r==Nr); T+Nr+2 OUT, dout_valid=1.
REQ-018 rnd_load, rnd_en, rnd_final SHALL be mutually exclusive except rnd_en&rnd_final on the last round; all 0 outside RUN.
REQ-019 OUT SHALL hold dout_valid=1 until dout_ready=1; on that cycle SHALL go to READY (din_ready=1 next cycle).
REQ-020 key_load in KEXP, RUN or OUT SHALL be ignored (not queued).
REQ-021 rk_addr SHALL be 0 in all states other than RUN.
REQ-022 Round counter SHALL be 4 bits and never exceed Nr.

Reset
REQ-023 On rst_n=0: state IDLE; kx_start, key_valid, din_ready, dout_valid, rnd_load, rnd_en, rnd_final=0; rk_addr=0; kx_nk=3; counters 0.
REQ-024 Reset mid-KEXP or mid-RUN SHALL abort immediately; after release a new key_load is required before din_ready=1.

Configuration
REQ-025 Macro AES_ROUND_CTRL_PERF_CNT_EN: when defined, SHALL add output blk_cnt (32): count of dout handshakes, saturating at 0xFFFFFFFF, reset to 0, cleared on accepted key_load.
REQ-026 Without AES_ROUND_CTRL_PERF_CNT_EN, blk_cnt and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-027 Reset then key_load, key_len=00 at cycle 0 -> kx_start high cycle 1 only, kx_nk=3, key_valid=1 from cycle 15.
REQ-028 key_len=10 loaded, din_valid at T -> rnd_load at T+1, rk_addr 1..14 on T+2..T+15, rnd_final only at T+15, dout_valid at T+16.
REQ-029 dout_ready held 0 for 5 cycles in OUT -> dout_valid stays 1, din_ready 0; dout_ready=1 -> READY, din_ready=1 next cycle.
REQ-030 key_load during RUN (key_len=01) -> ignored, round sequence and kx_nk unchanged; key_load and din_valid same cycle in READY -> KEXP, no block accepted.
REQ-031 rst_n pulsed low at round 5 -> all strobes 0 asynchronously, state IDLE, din_ready stays 0 until next key expansion completes.
REQ-032 With AES_ROUND_CTRL_PERF_CNT_EN, three blocks completed -> blk_cnt=3; new key_load -> blk_cnt=0.
